mc_controller: RTL and testbench

Multi-cycle sequencer for the MIPS datapath: replaces the single-cycle decoder with a state machine that spends one or more cycles per instruction phase (fetch, decode, execute, memory, write-back). It sits between the shared instruction/data memory port and the datapath. It drives PC/IR write enables, the memory request handshake, and every datapath select for the supported subset: lw, lb, sw, addi, addiu, ori, lui, beq, j, jal, addu, subu, slt, jr.

---
 rtl/mips_pkg.sv | 73 +++++++
 rtl/mc_controller_if.sv | 37 +++
 rtl/mc_controller_decode.sv | 67 ++++++
 rtl/mc_controller.sv | 147 ++++++++++++++
 tb/tb_mc_controller.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS constants for the multi-cycle controller: opcode/funct values,
// datapath select encodings, FSM state and instruction-class enums.
// Optional feature macro: OVF_TRAP_EN (adds the TRAP state).
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_SLT   = 6'b101010;
    localparam logic [5:0] FN_JR    = 6'b001000;

    localparam logic [2:0] ALUOP_ADD = 3'b000;
    localparam logic [2:0] ALUOP_OR  = 3'b001;
    localparam logic [2:0] ALUOP_SLT = 3'b010;
    localparam logic [2:0] ALUOP_SUB = 3'b011;
    localparam logic [2:0] ALUOP_LUI = 3'b100;

    localparam logic [1:0] NPC_SEQ = 2'b00;
    localparam logic [1:0] NPC_BR  = 2'b01;
    localparam logic [1:0] NPC_JMP = 2'b10;
    localparam logic [1:0] NPC_JR  = 2'b11;

    localparam logic [1:0] REGDST_RT = 2'b00;
    localparam logic [1:0] REGDST_RD = 2'b01;
    localparam logic [1:0] REGDST_RA = 2'b10;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC  = 2'b10;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_WB
`ifdef OVF_TRAP_EN
        , ST_TRAP
`endif
    } state_e;

    typedef enum logic [3:0] {
        IC_LOAD,
        IC_STORE,
        IC_ALU_I,
        IC_ALU_R,
        IC_BRANCH,
        IC_JUMP,
        IC_LINK,
        IC_JREG,
        IC_ILLEGAL
    } iclass_e;

    typedef struct packed {
        iclass_e    iclass;
        logic [2:0] aluop;
        logic       ext_sel;
        logic       is_byte;
        logic       is_addi;
    } dec_t;

endpackage

// File: rtl/mc_controller_if.sv
// Bundle of every controller <-> datapath/memory signal. The controller
// side uses the master modport, the datapath/memory side the slave modport.
interface mc_controller_if;

    logic [5:0] opcode;
    logic [5:0] funct;
    logic       alu_zero;
    logic       alu_ovf;
    logic       mem_ready;
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       pc_we;
    logic       ir_we;
    logic       regwrite;
    logic [1:0] regdst;
    logic [1:0] wb_sel;
    logic       alusrc;
    logic [2:0] aluop;
    logic       ext_sel;
    logic [1:0] npc_sel;
    logic       lb_flag;
    logic       ovf_exc;

    modport master (
        input  opcode, funct, alu_zero, alu_ovf, mem_ready,
        output mem_req, mem_we, iord, pc_we, ir_we, regwrite, regdst,
               wb_sel, alusrc, aluop, ext_sel, npc_sel, lb_flag, ovf_exc
    );

    modport slave (
        output opcode, funct, alu_zero, alu_ovf, mem_ready,
        input  mem_req, mem_we, iord, pc_we, ir_we, regwrite, regdst,
               wb_sel, alusrc, aluop, ext_sel, npc_sel, lb_flag, ovf_exc
    );

endinterface

// File: rtl/mc_controller_decode.sv
// mc_decode: purely combinational opcode/funct classifier. Produces the
// instruction class consumed by the FSM plus the ALU op and extension mode.
module mc_decode
    import mips_pkg::*;
(
    input  logic [5:0] opcode_i,
    input  logic [5:0] funct_i,
    output dec_t       dec_o
);

    // Map opcode/funct onto class, ALU operation and immediate extension
    always_comb begin
        dec_o.iclass  = IC_ILLEGAL;
        dec_o.aluop   = ALUOP_ADD;
        dec_o.ext_sel = 1'b1;
        dec_o.is_byte = 1'b0;
        dec_o.is_addi = 1'b0;
        case (opcode_i)
            OP_LW:    dec_o.iclass = IC_LOAD;
            OP_LB: begin
                dec_o.iclass  = IC_LOAD;
                dec_o.is_byte = 1'b1;
            end
            OP_SW:    dec_o.iclass = IC_STORE;
            OP_ADDI: begin
                dec_o.iclass  = IC_ALU_I;
                dec_o.is_addi = 1'b1;
            end
            OP_ADDIU: begin
                dec_o.iclass  = IC_ALU_I;
                dec_o.ext_sel = 1'b0;
            end
            OP_ORI: begin
                dec_o.iclass  = IC_ALU_I;
                dec_o.aluop   = ALUOP_OR;
                dec_o.ext_sel = 1'b0;
            end
            OP_LUI: begin
                dec_o.iclass = IC_ALU_I;
                dec_o.aluop  = ALUOP_LUI;
            end
            OP_BEQ: begin
                dec_o.iclass = IC_BRANCH;
                dec_o.aluop  = ALUOP_SUB;
            end
            OP_J:     dec_o.iclass = IC_JUMP;
            OP_JAL:   dec_o.iclass = IC_LINK;
            OP_RTYPE: begin
                case (funct_i)
                    FN_ADDU: dec_o.iclass = IC_ALU_R;
                    FN_SUBU: begin
                        dec_o.iclass = IC_ALU_R;
                        dec_o.aluop  = ALUOP_SUB;
                    end
                    FN_SLT: begin
                        dec_o.iclass = IC_ALU_R;
                        dec_o.aluop  = ALUOP_SLT;
                    end
                    FN_JR:   dec_o.iclass = IC_JREG;
                    default: dec_o.iclass = IC_ILLEGAL;
                endcase
            end
            default: dec_o.iclass = IC_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// mc_controller: multi-cycle MIPS sequencer (FETCH/DECODE/EXEC/MEM/WB).
// Outputs are decoded combinationally from the state register and the IR
// fields, and forced to 0 while rst_n is low so an abort takes effect at once.
// Optional feature macro: OVF_TRAP_EN (addi overflow diverts to TRAP).
module mc_controller
    import mips_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    mc_controller_if.master bus
);

    state_e state_q;
    dec_t   dec;

    mc_decode u_decode (
        .opcode_i (bus.opcode),
        .funct_i  (bus.funct),
        .dec_o    (dec)
    );

`ifndef OVF_TRAP_EN
    logic unused_ovf;
    assign unused_ovf = bus.alu_ovf ^ dec.is_addi;
`endif

    // State register with next-state selection per phase
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_FETCH;
        end else begin
            case (state_q)
                ST_FETCH: begin
                    if (bus.mem_ready) state_q <= ST_DECODE;
                end
                ST_DECODE: begin
                    case (dec.iclass)
                        IC_JUMP, IC_LINK, IC_JREG, IC_ILLEGAL: state_q <= ST_FETCH;
                        default:                               state_q <= ST_EXEC;
                    endcase
                end
                ST_EXEC: begin
                    case (dec.iclass)
                        IC_BRANCH:          state_q <= ST_FETCH;
                        IC_LOAD, IC_STORE:  state_q <= ST_MEM;
                        default: begin
`ifdef OVF_TRAP_EN
                            if (dec.is_addi && bus.alu_ovf) state_q <= ST_TRAP;
                            else                            state_q <= ST_WB;
`else
                            state_q <= ST_WB;
`endif
                        end
                    endcase
                end
                ST_MEM: begin
                    if (bus.mem_ready) begin
                        state_q <= (dec.iclass == IC_STORE) ? ST_FETCH : ST_WB;
                    end
                end
                ST_WB:   state_q <= ST_FETCH;
`ifdef OVF_TRAP_EN
                ST_TRAP: state_q <= ST_FETCH;
`endif
                default: state_q <= ST_FETCH;
            endcase
        end
    end

    // Datapath strobes and selects decoded from state plus instruction class
    always_comb begin
        bus.mem_req  = 1'b0;
        bus.mem_we   = 1'b0;
        bus.iord     = 1'b0;
        bus.pc_we    = 1'b0;
        bus.ir_we    = 1'b0;
        bus.regwrite = 1'b0;
        bus.regdst   = REGDST_RT;
        bus.wb_sel   = WB_ALU;
        bus.alusrc   = 1'b0;
        bus.aluop    = ALUOP_ADD;
        bus.ext_sel  = 1'b0;
        bus.npc_sel  = NPC_SEQ;
        bus.lb_flag  = 1'b0;
        bus.ovf_exc  = 1'b0;
        if (rst_n) begin
            // ALU controls stay stable from EXEC through MEM/WB
            if (state_q == ST_EXEC || state_q == ST_MEM || state_q == ST_WB) begin
                bus.aluop   = dec.aluop;
                bus.ext_sel = dec.ext_sel;
                bus.alusrc  = (dec.iclass != IC_ALU_R) && (dec.iclass != IC_BRANCH);
            end
            case (state_q)
                ST_FETCH: begin
                    bus.mem_req = 1'b1;
                    if (bus.mem_ready) begin
                        bus.ir_we = 1'b1;
                        bus.pc_we = 1'b1;
                    end
                end
                ST_DECODE: begin
                    case (dec.iclass)
                        IC_JUMP: begin
                            bus.pc_we   = 1'b1;
                            bus.npc_sel = NPC_JMP;
                        end
                        IC_LINK: begin
                            bus.pc_we    = 1'b1;
                            bus.npc_sel  = NPC_JMP;
                            bus.regwrite = 1'b1;
                            bus.regdst   = REGDST_RA;
                            bus.wb_sel   = WB_PC;
                        end
                        IC_JREG: begin
                            bus.pc_we   = 1'b1;
                            bus.npc_sel = NPC_JR;
                        end
                        default: ;
                    endcase
                end
                ST_EXEC: begin
                    if (dec.iclass == IC_BRANCH) begin
                        bus.npc_sel = NPC_BR;
                        bus.pc_we   = bus.alu_zero;
                    end
                end
                ST_MEM: begin
                    bus.mem_req = 1'b1;
                    bus.iord    = 1'b1;
                    bus.mem_we  = (dec.iclass == IC_STORE);
                    bus.lb_flag = dec.is_byte;
                end
                ST_WB: begin
                    bus.regwrite = 1'b1;
                    bus.lb_flag  = dec.is_byte;
                    if (dec.iclass == IC_LOAD)  bus.wb_sel = WB_MEM;
                    if (dec.iclass == IC_ALU_R) bus.regdst = REGDST_RD;
                end
`ifdef OVF_TRAP_EN
                ST_TRAP: bus.ovf_exc = 1'b1;
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mc_controller.sv
// Scoreboard bench for mc_controller: stimulus pushes the expected output
// bundle (with its cycle number) for every cycle that carries a strobe or a
// memory completion; a negedge monitor pops and compares each such cycle.
module tb_mc_controller;
    import mips_pkg::*;

    logic clk;
    logic rst_n;
    int   cyc;
    int   total;
    int   bad;

    typedef struct {
        int          cyc;
        logic [18:0] v;
    } exp_t;
    exp_t q[$];

    mc_controller_if bus ();

    mc_controller dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [18:0] b(
        input logic req, input logic we, input logic iord, input logic pcwe,
        input logic irwe, input logic rw, input logic [1:0] rd, input logic [1:0] wbs,
        input logic asrc, input logic [2:0] aop, input logic ext, input logic [1:0] npc,
        input logic lb, input logic ovf);
        return {req, we, iord, pcwe, irwe, rw, rd, wbs, asrc, aop, ext, npc, lb, ovf};
    endfunction

    function automatic logic [18:0] outs();
        return {bus.mem_req, bus.mem_we, bus.iord, bus.pc_we, bus.ir_we, bus.regwrite,
                bus.regdst, bus.wb_sel, bus.alusrc, bus.aluop, bus.ext_sel,
                bus.npc_sel, bus.lb_flag, bus.ovf_exc};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    // Monitor: every cycle with an observable strobe or memory completion
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (bus.pc_we || bus.ir_we || bus.regwrite || bus.ovf_exc ||
                (bus.mem_req && bus.mem_ready)) begin
                total++;
                if (q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_event: cycle %0d outputs %05h, none expected",
                             cyc, outs());
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    if (e.cyc != cyc || e.v !== outs()) begin
                        bad++;
                        $display("FAIL event: cycle %0d outputs %05h expected cycle %0d outputs %05h",
                                 cyc, outs(), e.cyc, e.v);
                    end
                end
            end
        end
    end

    task automatic step(input logic rdy, input logic z, input logic ov,
                        input bit ev, input logic [18:0] v);
        exp_t e;
        bus.mem_ready = rdy;
        bus.alu_zero  = z;
        bus.alu_ovf   = ov;
        if (ev) begin
            e.cyc = cyc;
            e.v   = v;
            q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [5:0] op, input logic [5:0] fn, input int waits);
        bus.opcode = op;
        bus.funct  = fn;
        repeat (waits) step(1'b0, 1'b0, 1'b0, 1'b0, '0);
        step(1'b1, 1'b0, 1'b0, 1'b1, b(1,0,0,1,1,0,2'b00,2'b00,0,3'b000,0,2'b00,0,0));
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 1'b0, '0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        cyc = 0;
        total = 0;
        bad = 0;
        rst_n = 1'b0;
        bus.opcode = '0;
        bus.funct = '0;
        bus.mem_ready = 1'b0;
        bus.alu_zero = 1'b0;
        bus.alu_ovf = 1'b0;
        #1;
        chk("reset_outputs", {13'd0, outs()}, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("first_mem_req", {31'd0, bus.mem_req}, 32'd1);
        chk("first_iord", {31'd0, bus.iord}, 32'd0);

        // lw: one wait in FETCH and one in MEM -> 7 cycles
        fetch(OP_LW, 6'd0, 1);
        idle();
        idle();
        idle();
        step(1, 0, 0, 1, b(1,0,1,0,0,0,2'b00,2'b00,1,3'b000,1,2'b00,0,0));
        step(0, 0, 0, 1, b(0,0,0,0,0,1,2'b00,2'b01,1,3'b000,1,2'b00,0,0));

        // lb zero-wait: lb_flag in MEM and WB
        fetch(OP_LB, 6'd0, 0);
        idle();
        idle();
        step(1, 0, 0, 1, b(1,0,1,0,0,0,2'b00,2'b00,1,3'b000,1,2'b00,1,0));
        step(0, 0, 0, 1, b(0,0,0,0,0,1,2'b00,2'b01,1,3'b000,1,2'b00,1,0));

        // sw zero-wait: write request in MEM, back to FETCH
        fetch(OP_SW, 6'd0, 0);
        idle();
        idle();
        step(1, 0, 0, 1, b(1,1,1,0,0,0,2'b00,2'b00,1,3'b000,1,2'b00,0,0));

        // beq taken, then not taken
        fetch(OP_BEQ, 6'd0, 0);
        idle();
        step(0, 1, 0, 1, b(0,0,0,1,0,0,2'b00,2'b00,0,3'b011,1,2'b01,0,0));
        fetch(OP_BEQ, 6'd0, 0);
        idle();
        step(0, 0, 0, 0, '0);

        // jal, j, jr resolve in DECODE
        fetch(OP_JAL, 6'd0, 0);
        step(0, 0, 0, 1, b(0,0,0,1,0,1,2'b10,2'b10,0,3'b000,0,2'b10,0,0));
        fetch(OP_J, 6'd0, 0);
        step(0, 0, 0, 1, b(0,0,0,1,0,0,2'b00,2'b00,0,3'b000,0,2'b10,0,0));
        fetch(OP_RTYPE, FN_JR, 0);
        step(0, 0, 0, 1, b(0,0,0,1,0,0,2'b00,2'b00,0,3'b000,0,2'b11,0,0));

        // immediate and register ALU ops
        fetch(OP_ORI, 6'd0, 0);
        idle();
        idle();
        step(0, 0, 0, 1, b(0,0,0,0,0,1,2'b00,2'b00,1,3'b001,0,2'b00,0,0));
        fetch(OP_ADDIU, 6'd0, 0);
        idle();
        idle();
        step(0, 0, 0, 1, b(0,0,0,0,0,1,2'b00,2'b00,1,3'b000,0,2'b00,0,0));
        fetch(OP_LUI, 6'd0, 0);
        idle();
        idle();
        step(0, 0, 0, 1, b(0,0,0,0,0,1,2'b00,2'b00,1,3'b100,1,2'b00,0,0));
        fetch(OP_RTYPE, FN_SUBU, 0);
        idle();
        idle();
        step(0, 0, 0, 1, b(0,0,0,0,0,1,2'b01,2'b00,0,3'b011,1,2'b00,0,0));
        fetch(OP_RTYPE, FN_SLT, 0);
        idle();
        idle();
        step(0, 0, 0, 1, b(0,0,0,0,0,1,2'b01,2'b00,0,3'b010,1,2'b00,0,0));

        // unknown opcode and unknown funct: silent DECODE, then FETCH
        fetch(6'b111111, 6'd0, 0);
        idle();
        fetch(OP_RTYPE, 6'b111111, 0);
        idle();

        // addi with overflow
        fetch(OP_ADDI, 6'd0, 0);
        idle();
        step(0, 0, 1, 0, '0);
`ifdef OVF_TRAP_EN
        step(0, 0, 0, 1, b(0,0,0,0,0,0,2'b00,2'b00,0,3'b000,0,2'b00,0,1));
`else
        step(0, 0, 0, 1, b(0,0,0,0,0,1,2'b00,2'b00,1,3'b000,1,2'b00,0,0));
`endif

        // reset during a stalled sw MEM phase
        fetch(OP_SW, 6'd0, 0);
        idle();
        idle();
        idle();
        chk("sw_mem_req_before_reset", {31'd0, bus.mem_req}, 32'd1);
        chk("sw_mem_we_before_reset", {31'd0, bus.mem_we}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_mem_req", {31'd0, bus.mem_req}, 32'd0);
        chk("abort_mem_we", {31'd0, bus.mem_we}, 32'd0);
        chk("abort_all_outputs", {13'd0, outs()}, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("restart_mem_req", {31'd0, bus.mem_req}, 32'd1);
        chk("restart_iord", {31'd0, bus.iord}, 32'd0);
        chk("restart_mem_we", {31'd0, bus.mem_we}, 32'd0);

        // normal instruction after the abort
        fetch(OP_RTYPE, FN_ADDU, 0);
        idle();
        idle();
        step(0, 0, 0, 1, b(0,0,0,0,0,1,2'b01,2'b00,0,3'b000,1,2'b00,0,0));

        idle();
        idle();
        chk("scoreboard_drained", q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
